// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB-first, WIDTH cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module Full_Adder_Dataflow (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
    logic             c_msb_q, c_msb_d;
`endif

    Full_Adder_Dataflow u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        c_msb_d  = c_msb_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                // Results are published only on the final bit so partial sums never show.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = sum_sr_d;
                    cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
                    c_msb_d = carry_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            c_msb_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            c_msb_q  <= c_msb_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    // Both terms are captured together on entry to DONE, so ovf holds with sum.
    assign ovf  = c_msb_q ^ cout_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed steps plus a result scoreboard.
// Define SERIAL_ADD_OVF_EN to also check the ovf output.

module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_count  = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        logic [WIDTH:0] t;
        exp_t           e;
        t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_count++;
            check("sb_nonempty_at_done", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_sum", 32'(sum), 32'(e.sum));
                check("sb_cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic ci, input bit push);
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        if (push) sb.push_back(model(x, y, ci));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 32'(done === 1'b1), 32'd1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with cycle-exact latency.
        start_add(8'h5A, 8'h3C, 1'b0, 1'b1);
        check("t1_busy_c1", 32'(busy), 32'd1);
        check("t1_done_c1", 32'(done), 32'd0);
        check("t1_no_partial_sum", 32'(sum), 32'd0);
        for (int i = 2; i <= WIDTH; i++) begin
            @(negedge clk);
            check($sformatf("t1_busy_c%0d", i), 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_sum", 32'(sum), 32'h96);
        check("t1_cout", 32'(cout), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_sum_held", 32'(sum), 32'h96);

        // Carry out of MSB, then carry-in only; previous result held during RUN.
        start_add(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done(WIDTH + 4);
        @(negedge clk);
        start_add(8'h00, 8'h00, 1'b1, 1'b1);
        check("t2_sum_held_run", 32'(sum), 32'h00);
        check("t2_cout_held_run", 32'(cout), 32'd1);
        wait_done(WIDTH + 4);
        check("t2_sum", 32'(sum), 32'h01);
        @(negedge clk);

        // start re-asserted with new operands during RUN and DONE is ignored.
        d0 = done_count;
        start_add(8'h12, 8'h34, 1'b0, 1'b1);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        wait_done(WIDTH + 4);
        @(negedge clk);
        start = 1'b0;
        check("t3_no_restart", 32'(busy), 32'd0);
        repeat (WIDTH + 4) @(negedge clk);
        check("t3_one_done", 32'(done_count - d0), 32'd1);
        check("t3_sum", 32'(sum), 32'h46);

        // Reset in the middle of RUN aborts the add.
        start_add(8'h55, 8'h66, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        d0    = done_count;
        rst_n = 1'b0;
        #1;
        check("t4_busy_clr", 32'(busy), 32'd0);
        check("t4_done_clr", 32'(done), 32'd0);
        check("t4_sum_clr", 32'(sum), 32'd0);
        check("t4_cout_clr", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 4) @(negedge clk);
        check("t4_no_done", 32'(done_count - d0), 32'd0);
        start_add(8'h01, 8'h01, 1'b0, 1'b1);
        wait_done(WIDTH + 4);
        check("t4_sum_after", 32'(sum), 32'h02);
        @(negedge clk);

        // Signed-overflow corner vectors (sum/cout checked in every build).
        start_add(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_done(WIDTH + 4);
        check("t6_sum_7f", 32'(sum), 32'h80);
        @(negedge clk);
        start_add(8'h80, 8'h80, 1'b0, 1'b1);
        wait_done(WIDTH + 4);
        check("t6_cout_80", 32'(cout), 32'd1);
        @(negedge clk);
        start_add(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(WIDTH + 4);
        @(negedge clk);

        // Back-to-back random adds with start held high.
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        start = 1'b1;
        sb.push_back(model(a, b, cin));
        for (int i = 0; i < 256; i++) begin
            wait_done(WIDTH + 6);
            if (i < 255) begin
                a   = WIDTH'($urandom);
                b   = WIDTH'($urandom);
                cin = 1'($urandom);
                sb.push_back(model(a, b, cin));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("t5_idle_gap", 32'(busy), 32'd0);
            if (i < 255) begin
                @(negedge clk);
                check("t5_b2b_accept", 32'(busy), 32'd1);
            end
        end
        repeat (WIDTH + 4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
